io_port_arbiter: RTL and testbench

Two-master arbiter and access sequencer for the memory-mapped I/O port block. It sits between two requesters (m0: CPU load/store stage; m1: debug/DMA engine) and the I/O port block's single shared address/strobe interface. It serialises accesses, generates the port read/write strobes for exactly one cycle per access, and returns read data with a one-cycle acknowledge.

---
 rtl/io_port_arbiter.sv | 136 +++++++++++++
 tb/tb_io_port_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/io_port_arbiter.sv
// Two-master arbiter and three-phase access sequencer (IDLE/ACCESS/DONE) for the I/O port block.
// Define IO_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise m0 has fixed priority.
module io_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic [ADDR_W-1:0] io_access_addr,
  output logic [DATA_W-1:0] io_in,
  output logic              io_write_en,
  output logic              io_read_en,
  input  logic [DATA_W-1:0] io_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                grant_q, grant_d;
  logic [DATA_W-1:0]   m0Rdata_q, m0Rdata_d;
  logic [DATA_W-1:0]   m1Rdata_q, m1Rdata_d;
  logic                winner;
  logic                anyReq;
  logic                isAccess;
  logic                portSpace;
  logic [DATA_W-1:0]   readVal;

  assign anyReq = m0_req | m1_req;

`ifdef IO_ARB_ROUND_ROBIN_EN
  logic lastGrant_q, lastGrant_d;

  // On a tie the master not granted last wins; a lone requester always wins.
  always_comb begin
    winner = 1'b1;
    if (m0_req) begin
      winner = m1_req ? ~lastGrant_q : 1'b0;
    end
    lastGrant_d = lastGrant_q;
    if ((state_q == IDLE) && anyReq) begin
      lastGrant_d = winner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant_q <= 1'b1;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end
`else
  assign winner = ~m0_req;
`endif

  // Non-port addresses complete without a strobe and return zero.
  assign portSpace = addr_q[ADDR_W-1];
  assign readVal   = portSpace ? io_out : '0;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    grant_d   = grant_q;
    m0Rdata_d = m0Rdata_q;
    m1Rdata_d = m1Rdata_q;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          state_d = ACCESS;
          grant_d = winner;
          we_d    = winner ? m1_we    : m0_we;
          addr_d  = winner ? m1_addr  : m0_addr;
          wdata_d = winner ? m1_wdata : m0_wdata;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (!we_q) begin
          if (grant_q) m1Rdata_d = readVal;
          else         m0Rdata_d = readVal;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      grant_q   <= 1'b0;
      m0Rdata_q <= '0;
      m1Rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      grant_q   <= grant_d;
      m0Rdata_q <= m0Rdata_d;
      m1Rdata_q <= m1Rdata_d;
    end
  end

  // Port-side outputs decode only registered state, never the master inputs.
  assign isAccess       = (state_q == ACCESS);
  assign io_access_addr = isAccess ? addr_q  : '0;
  assign io_in          = isAccess ? wdata_q : '0;
  assign io_write_en    = isAccess &  we_q & portSpace;
  assign io_read_en     = isAccess & ~we_q & portSpace;
  assign m0_ack         = (state_q == DONE) & ~grant_q;
  assign m1_ack         = (state_q == DONE) &  grant_q;
  assign m0_rdata       = m0Rdata_q;
  assign m1_rdata       = m1Rdata_q;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Directed self-checking bench for io_port_arbiter; expected tie-break order
// follows IO_ARB_ROUND_ROBIN_EN exactly as the design build does.
module tb_io_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [15:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic [15:0] io_access_addr, io_in, io_out;
  logic        io_write_en, io_read_en;

  int   total = 0;
  int   bad   = 0;
  logic expG;

  io_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .io_access_addr(io_access_addr), .io_in(io_in),
    .io_write_en(io_write_en), .io_read_en(io_read_en), .io_out(io_out)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    io_out = '0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_m0_ack", m0_ack, 0);
    checkOutput("rst_m1_ack", m1_ack, 0);
    checkOutput("rst_m0_rdata", m0_rdata, 0);
    checkOutput("rst_m1_rdata", m1_rdata, 0);
    checkOutput("rst_io_addr", io_access_addr, 0);
    checkOutput("rst_io_strobes", {io_write_en, io_read_en}, 0);
    rst = 1'b0;

    // m0 read 0x8001 so m0_rdata carries a known nonzero value
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h8001; io_out = 16'hA5A5;
    applyStimulus();
    checkOutput("rd0_read_en", io_read_en, 1);
    checkOutput("rd0_write_en", io_write_en, 0);
    checkOutput("rd0_addr", io_access_addr, 16'h8001);
    applyStimulus();
    checkOutput("rd0_ack", m0_ack, 1);
    checkOutput("rd0_rdata", m0_rdata, 16'hA5A5);
    checkOutput("rd0_read_en_done", io_read_en, 0);
    m0_req = 1'b0;
    applyStimulus();
    checkOutput("rd0_ack_low", m0_ack, 0);

    // m0 write 0x8003 / 0xBEEF
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h8003; m0_wdata = 16'hBEEF; io_out = 16'h4444;
    applyStimulus();
    checkOutput("wr0_write_en", io_write_en, 1);
    checkOutput("wr0_read_en", io_read_en, 0);
    checkOutput("wr0_addr", io_access_addr, 16'h8003);
    checkOutput("wr0_io_in", io_in, 16'hBEEF);
    checkOutput("wr0_ack_early", m0_ack, 0);
    applyStimulus();
    checkOutput("wr0_ack", m0_ack, 1);
    checkOutput("wr0_write_en_done", io_write_en, 0);
    checkOutput("wr0_addr_done", io_access_addr, 0);
    checkOutput("wr0_io_in_done", io_in, 0);
    checkOutput("wr0_rdata_kept", m0_rdata, 16'hA5A5);
    m0_req = 1'b0;
    applyStimulus();
    checkOutput("wr0_ack_low", m0_ack, 0);

    // m1 read 0x8000 returns 0x1234, m0 rdata untouched
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h8000; io_out = 16'h1234;
    applyStimulus();
    checkOutput("rd1_read_en", io_read_en, 1);
    checkOutput("rd1_addr", io_access_addr, 16'h8000);
    applyStimulus();
    checkOutput("rd1_ack", m1_ack, 1);
    checkOutput("rd1_m0_ack", m0_ack, 0);
    checkOutput("rd1_rdata", m1_rdata, 16'h1234);
    checkOutput("rd1_m0_rdata", m0_rdata, 16'hA5A5);
    m1_req = 1'b0;
    applyStimulus();
    checkOutput("rd1_ack_low", m1_ack, 0);
    checkOutput("rd1_rdata_held", m1_rdata, 16'h1234);

    // m0 read of non-port address 0x0010: no strobe, rdata zero
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010; io_out = 16'hFFFF;
    applyStimulus();
    checkOutput("np_strobes", {io_write_en, io_read_en}, 0);
    applyStimulus();
    checkOutput("np_ack", m0_ack, 1);
    checkOutput("np_rdata", m0_rdata, 0);
    m0_req = 1'b0;
    applyStimulus();

    // m1 write leaves the last-grant pointer on m1
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h8300; m1_wdata = 16'h0F0F;
    applyStimulus();
    checkOutput("wr1_write_en", io_write_en, 1);
    checkOutput("wr1_io_in", io_in, 16'h0F0F);
    applyStimulus();
    checkOutput("wr1_ack", m1_ack, 1);
    checkOutput("wr1_rdata_kept", m1_rdata, 16'h1234);
    m1_req = 1'b0;
    applyStimulus();

    // Both masters held high for four accesses
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h8100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h8200;
    io_out = 16'h1111;
    for (int i = 0; i < 4; i++) begin
`ifdef IO_ARB_ROUND_ROBIN_EN
      expG = (i % 2 == 1);
`else
      expG = 1'b0;
`endif
      applyStimulus();
      checkOutput($sformatf("tie%0d_addr", i), io_access_addr, expG ? 16'h8200 : 16'h8100);
      applyStimulus();
      checkOutput($sformatf("tie%0d_m0_ack", i), m0_ack, !expG);
      checkOutput($sformatf("tie%0d_m1_ack", i), m1_ack, expG);
      if (i == 3) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      applyStimulus();
      checkOutput($sformatf("tie%0d_idle", i), io_read_en, 0);
    end

    // Reset while in ACCESS drops the access; pending m0 then completes
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h8400; io_out = 16'h7777;
    applyStimulus();
    checkOutput("rsta_read_en", io_read_en, 1);
    rst = 1'b1;
    applyStimulus();
    checkOutput("rsta_m0_ack", m0_ack, 0);
    checkOutput("rsta_m1_ack", m1_ack, 0);
    checkOutput("rsta_read_en_off", io_read_en, 0);
    checkOutput("rsta_addr", io_access_addr, 0);
    checkOutput("rsta_m0_rdata", m0_rdata, 0);
    checkOutput("rsta_m1_rdata", m1_rdata, 0);
    rst = 1'b0;
    applyStimulus();
    checkOutput("rstb_read_en", io_read_en, 1);
    checkOutput("rstb_addr", io_access_addr, 16'h8400);
    applyStimulus();
    checkOutput("rstb_ack", m0_ack, 1);
    checkOutput("rstb_rdata", m0_rdata, 16'h7777);
    m0_req = 1'b0;
    applyStimulus();
    checkOutput("rstb_ack_low", m0_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
